// File: rtl/vid_palette_ctrl.sv
// ============================================================================
// Module   : vid_palette_ctrl
// Purpose  : Palette RAM write-side controller. It arbitrates CPU writes
//            against a bulk stream loader, with optional vblank gating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vid_palette_ctrl #(
    parameter bit GATE_VBLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vid_vblank,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [7:0]  cpu_addr,
    input  logic [23:0] cpu_data,
    input  logic        bulk_start,
    input  logic [7:0]  bulk_base,
    input  logic [7:0]  bulk_len,
    input  logic        bulk_abort,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pal_w_addr,
    output logic [23:0] pal_w_data,
    output logic        pal_w_ena
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    // The reset value of last_grant is BULK, so the CPU wins the first conflict.
    localparam logic c_GRANT_BULK = 1'b0;
    localparam logic c_GRANT_CPU  = 1'b1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_idx;
    logic [7:0]  r_cnt;
    logic        r_last_grant;
    logic        r_done;

    logic        w_open;
    logic        w_cpu_req;
    logic        w_blk_req;
    logic        w_grant_cpu;
    logic        w_grant_blk;

    assign w_open    = (GATE_VBLANK == 1'b0) || vid_vblank;
    assign w_cpu_req = cpu_valid && w_open;
    assign w_blk_req = s_valid && w_open && (r_state == S_LOAD);

    // When both requesters are active, the one that did not win last time is granted.
    assign w_grant_cpu = rst_n && w_cpu_req && (!w_blk_req || (r_last_grant == c_GRANT_BULK));
    assign w_grant_blk = rst_n && w_blk_req && (!w_cpu_req || (r_last_grant == c_GRANT_CPU));

    assign cpu_ready = w_grant_cpu;
    assign s_ready   = w_grant_blk;
    assign busy      = (r_state == S_LOAD);
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bulk_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if ((w_grant_blk && (r_cnt == 8'd0)) || bulk_abort) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 8'd0;
            r_cnt <= 8'd0;
        end else if ((r_state == S_IDLE) && bulk_start) begin
            r_idx <= bulk_base;
            r_cnt <= bulk_len;
        end else if (w_grant_blk) begin
            r_idx <= r_idx + 8'd1;
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_GRANT_BULK;
            r_done       <= 1'b0;
            pal_w_ena    <= 1'b0;
            pal_w_addr   <= 8'd0;
            pal_w_data   <= 24'd0;
        end else begin
            r_done    <= w_grant_blk && (r_cnt == 8'd0);
            pal_w_ena <= w_grant_cpu || w_grant_blk;
            if (w_grant_cpu) begin
                r_last_grant <= c_GRANT_CPU;
                pal_w_addr   <= cpu_addr;
                pal_w_data   <= cpu_data;
            end else if (w_grant_blk) begin
                r_last_grant <= c_GRANT_BULK;
                pal_w_addr   <= r_idx;
                pal_w_data   <= s_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vid_palette_ctrl.sv
// ============================================================================
// Module   : tb_vid_palette_ctrl
// Purpose  : Bench for vid_palette_ctrl, with one ungated and one vblank-gated
//            instance sharing the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vid_palette_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vid_vblank = 1'b0;
    logic        cpu_valid = 1'b0;
    logic [7:0]  cpu_addr = 8'd0;
    logic [23:0] cpu_data = 24'd0;
    logic        bulk_start = 1'b0;
    logic [7:0]  bulk_base = 8'd0;
    logic [7:0]  bulk_len = 8'd0;
    logic        bulk_abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_data = 24'd0;

    logic        cpu_rdy [2];
    logic        s_rdy   [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [7:0]  wa      [2];
    logic [23:0] wd      [2];
    logic        we      [2];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    vid_palette_ctrl #(.GATE_VBLANK(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .vid_vblank(vid_vblank),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_rdy[0]), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .bulk_start(bulk_start), .bulk_base(bulk_base), .bulk_len(bulk_len), .bulk_abort(bulk_abort),
        .s_valid(s_valid), .s_ready(s_rdy[0]), .s_data(s_data),
        .busy(busy_o[0]), .done(done_o[0]),
        .pal_w_addr(wa[0]), .pal_w_data(wd[0]), .pal_w_ena(we[0])
    );

    vid_palette_ctrl #(.GATE_VBLANK(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vid_vblank(vid_vblank),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_rdy[1]), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .bulk_start(bulk_start), .bulk_base(bulk_base), .bulk_len(bulk_len), .bulk_abort(bulk_abort),
        .s_valid(s_valid), .s_ready(s_rdy[1]), .s_data(s_data),
        .busy(busy_o[1]), .done(done_o[1]),
        .pal_w_addr(wa[1]), .pal_w_data(wd[1]), .pal_w_ena(we[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one bulk job (active, next index, entries left) and
    // the identity of the last winner, per instance.
    bit          m_load    [2];
    logic [7:0]  m_idx     [2];
    logic [7:0]  m_rem     [2];
    bit          m_lastcpu [2];
    bit          e_ena     [2];
    bit          e_done    [2];
    logic [7:0]  e_addr    [2];
    logic [23:0] e_data    [2];
    bit          mo, mcr, mbr, mgc, mgb, mwas;

    initial begin
        for (int g = 0; g < 2; g++) begin
            m_load[g] = 0; m_idx[g] = 0; m_rem[g] = 0; m_lastcpu[g] = 0;
            e_ena[g] = 0; e_done[g] = 0; e_addr[g] = 0; e_data[g] = 0;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                chk($sformatf("m%0d_rst_cpu_ready", g), 32'(cpu_rdy[g]), 0);
                chk($sformatf("m%0d_rst_s_ready", g), 32'(s_rdy[g]), 0);
                chk($sformatf("m%0d_rst_ena", g), 32'(we[g]), 0);
                chk($sformatf("m%0d_rst_busy", g), 32'(busy_o[g]), 0);
                chk($sformatf("m%0d_rst_done", g), 32'(done_o[g]), 0);
                m_load[g] = 0; m_idx[g] = 0; m_rem[g] = 0; m_lastcpu[g] = 0;
                e_ena[g] = 0; e_done[g] = 0; e_addr[g] = 0; e_data[g] = 0;
            end else begin
                mo  = (g == 0) || vid_vblank;
                mcr = cpu_valid && mo;
                mbr = s_valid && mo && m_load[g];
                mgc = mcr && !(mbr && m_lastcpu[g]);
                mgb = mbr && !mgc;
                chk($sformatf("m%0d_cpu_ready", g), 32'(cpu_rdy[g]), 32'(mgc));
                chk($sformatf("m%0d_s_ready", g), 32'(s_rdy[g]), 32'(mgb));
                chk($sformatf("m%0d_busy", g), 32'(busy_o[g]), 32'(m_load[g]));
                chk($sformatf("m%0d_done", g), 32'(done_o[g]), 32'(e_done[g]));
                chk($sformatf("m%0d_ena", g), 32'(we[g]), 32'(e_ena[g]));
                chk($sformatf("m%0d_addr", g), 32'(wa[g]), 32'(e_addr[g]));
                chk($sformatf("m%0d_data", g), 32'(wd[g]), 32'(e_data[g]));
                // Advance the model across the coming rising edge.
                mwas      = m_load[g];
                e_ena[g]  = mgc || mgb;
                e_done[g] = mgb && (m_rem[g] == 0);
                if (mgc) begin
                    e_addr[g] = cpu_addr; e_data[g] = cpu_data; m_lastcpu[g] = 1;
                end else if (mgb) begin
                    e_addr[g] = m_idx[g]; e_data[g] = s_data; m_lastcpu[g] = 0;
                    m_idx[g] = 8'((int'(m_idx[g]) + 1) % 256);
                    if (m_rem[g] == 0) m_load[g] = 0;
                    else m_rem[g] = m_rem[g] - 1;
                end
                if (mwas && bulk_abort) m_load[g] = 0;
                if (!mwas && bulk_start) begin
                    m_load[g] = 1; m_idx[g] = bulk_base; m_rem[g] = bulk_len;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ea;

    initial begin
        // Reset state
        #3;
        chk("rst_ena0", 32'(we[0]), 0);
        chk("rst_busy0", 32'(busy_o[0]), 0);
        chk("rst_addr0", 32'(wa[0]), 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Ungated CPU write; the gated instance stays closed
        cpu_valid = 1; cpu_addr = 8'h10; cpu_data = 24'hFF8040;
        #2;
        chk("t1_cpu_ready0", 32'(cpu_rdy[0]), 1);
        chk("t1_cpu_ready1_closed", 32'(cpu_rdy[1]), 0);
        cyc(); cpu_valid = 0; #2;
        chk("t1_ena", 32'(we[0]), 1);
        chk("t1_addr", 32'(wa[0]), 32'h10);
        chk("t1_data", 32'(wd[0]), 32'hFF8040);
        cyc(); #2;
        chk("t1_ena_after", 32'(we[0]), 0);

        // Vblank gating on the gated instance
        cyc();
        cpu_valid = 1; cpu_addr = 8'h33; cpu_data = 24'h123456;
        for (int k = 0; k < 20; k++) begin
            #2;
            chk("t2_gated_ready", 32'(cpu_rdy[1]), 0);
            chk("t2_gated_ena", 32'(we[1]), 0);
            cyc();
        end
        vid_vblank = 1; #2;
        chk("t2_vblank_ready", 32'(cpu_rdy[1]), 1);
        cyc(); cpu_valid = 0; vid_vblank = 0; #2;
        chk("t2_ena", 32'(we[1]), 1);
        chk("t2_addr", 32'(wa[1]), 32'h33);
        chk("t2_data", 32'(wd[1]), 32'h123456);

        // Bulk load wrapping past 0xFF
        cyc();
        bulk_start = 1; bulk_base = 8'hFE; bulk_len = 8'd3;
        cyc(); bulk_start = 0; s_valid = 1;
        for (int k = 0; k < 5; k++) begin
            s_data = 24'hA00000 + 24'(k);
            #2;
            chk("t3_s_ready", 32'(s_rdy[0]), (k < 4) ? 1 : 0);
            if (k > 0) begin
                ea = 8'hFE + 8'(k - 1);
                chk("t3_ena", 32'(we[0]), 1);
                chk("t3_addr", 32'(wa[0]), 32'(ea));
                chk("t3_data", 32'(wd[0]), 32'hA00000 + 32'(k - 1));
            end
            chk("t3_done", 32'(done_o[0]), (k == 4) ? 1 : 0);
            chk("t3_busy", 32'(busy_o[0]), (k == 4) ? 0 : 1);
            cyc();
        end
        s_valid = 0; #2;
        chk("t3_done_once", 32'(done_o[0]), 0);
        chk("t3_no_fifth", 32'(we[0]), 0);

        // Conflict: CPU first, then alternation
        cyc();
        bulk_start = 1; bulk_base = 8'h40; bulk_len = 8'hFF;
        cyc(); bulk_start = 0;
        cpu_valid = 1; cpu_addr = 8'h55; cpu_data = 24'h111111;
        s_valid = 1; s_data = 24'h222222;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("t4_cpu_ready", 32'(cpu_rdy[0]), (k % 2 == 0) ? 1 : 0);
            chk("t4_s_ready", 32'(s_rdy[0]), (k % 2 == 1) ? 1 : 0);
            if (k > 0) begin
                ea = ((k - 1) % 2 == 0) ? 8'h55 : 8'h40 + 8'((k - 1) / 2);
                chk("t4_addr", 32'(wa[0]), 32'(ea));
            end
            cyc();
        end
        cpu_valid = 0; s_valid = 0; bulk_abort = 1;
        cyc(); bulk_abort = 0; #2;
        chk("t4_abort_busy", 32'(busy_o[0]), 0);

        // Abort after five beats, then restart at a new base
        cyc();
        bulk_start = 1; bulk_base = 8'h20; bulk_len = 8'hFF;
        cyc(); bulk_start = 0; s_valid = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) bulk_abort = 1;
            #2;
            chk("t5_s_ready", 32'(s_rdy[0]), 1);
            cyc();
        end
        bulk_abort = 0; #2;
        chk("t5_last_ena", 32'(we[0]), 1);
        chk("t5_last_addr", 32'(wa[0]), 32'h24);
        chk("t5_busy", 32'(busy_o[0]), 0);
        chk("t5_idle_s_ready", 32'(s_rdy[0]), 0);
        cyc(); #2;
        chk("t5_no_done", 32'(done_o[0]), 0);
        bulk_start = 1; bulk_base = 8'h80; bulk_len = 8'd1; s_valid = 0;
        cyc();
        bulk_start = 1; bulk_base = 8'h10; bulk_len = 8'd5; s_valid = 1;
        #2;
        chk("t5_restart_busy", 32'(busy_o[0]), 1);
        cyc(); bulk_start = 0; #2;
        chk("t5_addr80", 32'(wa[0]), 32'h80);
        cyc(); #2;
        chk("t5_addr81", 32'(wa[0]), 32'h81);
        chk("t5_done", 32'(done_o[0]), 1);
        s_valid = 0;

        // Asynchronous reset in the middle of a load
        cyc();
        bulk_start = 1; bulk_base = 8'h00; bulk_len = 8'hFF;
        cyc(); bulk_start = 0; s_valid = 1;
        cyc();
        chk("t6_pre_ena", 32'(we[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_ena", 32'(we[0]), 0);
        chk("t6_async_busy", 32'(busy_o[0]), 0);
        chk("t6_async_done", 32'(done_o[0]), 0);
        cyc(); rst_n = 1'b1; #2;
        chk("t6_post_busy", 32'(busy_o[0]), 0);
        chk("t6_post_s_ready", 32'(s_rdy[0]), 0);

        // Randomized traffic checked against the model
        for (int k = 0; k < 3000; k++) begin
            cyc();
            if ($urandom_range(0, 7) == 0) vid_vblank = ~vid_vblank;
            cpu_valid  = ($urandom_range(0, 2) == 0);
            cpu_addr   = 8'($urandom);
            cpu_data   = 24'($urandom);
            s_valid    = ($urandom_range(0, 3) != 0);
            s_data     = 24'($urandom);
            bulk_start = ($urandom_range(0, 15) == 0);
            bulk_base  = 8'($urandom);
            bulk_len   = 8'($urandom_range(0, 12));
            bulk_abort = ($urandom_range(0, 40) == 0);
        end
        cyc();
        cpu_valid = 0; s_valid = 0; bulk_start = 0; bulk_abort = 0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vid_palette_ctrl.md
Name: vid_palette_ctrl

Overview:
Write-side controller for the 256-entry x 24-bit video palette RAM.
- Arbitrates between a CPU single-entry write requester and a streaming bulk loader. The bulk loader fills N consecutive entries from a base index.
- Optionally holds all writes until vertical blank, so palette changes never tear mid-frame.
- Drives the palette write port (address, data, enable) with one registered cycle of latency. The video read side is untouched.

Parameters:
GATE_VBLANK, 1, 1: writes are issued only while vid_vblank=1; 0: writes are issued whenever arbitration allows.

Ports:
clk  in  1  single system/video clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
vid_vblank  in  1  vertical blank indicator, synchronous to clk
cpu_valid  in  1  CPU write request
cpu_ready  out  1  CPU write accepted this cycle (combinational)
cpu_addr  in  8  CPU target palette index
cpu_data  in  24  CPU RGB data
bulk_start  in  1  one-cycle pulse that starts a bulk load
bulk_base  in  8  first index of the bulk load, sampled with bulk_start
bulk_len  in  8  entry count minus 1 (0 means 1 entry, 255 means 256 entries), sampled with bulk_start
bulk_abort  in  1  cancels an active bulk load
s_valid  in  1  bulk stream data valid
s_ready  out  1  bulk stream beat accepted this cycle (combinational)
s_data  in  24  bulk stream RGB data
busy  out  1  bulk load active
done  out  1  one-cycle pulse when a bulk load completes normally
pal_w_addr  out  8  palette write address (registered)
pal_w_data  out  24  palette write data (registered)
pal_w_ena  out  1  palette write enable (registered)

Behaviour:
Reset:
- rst_n=0 asynchronously clears pal_w_addr, pal_w_data, pal_w_ena, busy, done, the bulk index, the bulk count and last_grant.
- Resulting state is IDLE with last_grant=BULK, so the CPU wins the first conflict.
- cpu_ready and s_ready are 0 during reset.

Gate:
- open = (GATE_VBLANK==0) | vid_vblank.
- Gate evaluation is combinational in the same cycle, so a write accepted on the last vblank cycle still issues.

States:
- IDLE: busy=0.
  - bulk_start=1 captures idx<=bulk_base and cnt<=bulk_len, then moves to LOAD.
- LOAD: busy=1.
  - bulk_start in LOAD is ignored; base and length are not reloaded.
  - On each accepted stream beat: idx<=idx+1, wrapping 255 to 0 modulo 256; cnt<=cnt-1.
  - Beat accepted with cnt==0 moves to IDLE, and done=1 on the following cycle.
  - bulk_abort=1 moves to IDLE next cycle with no done pulse. A beat accepted in the same cycle as abort is still written.
  - Abort in IDLE has no effect.

Arbitration (combinational, per cycle):
- cpu_req = cpu_valid & open.
- blk_req = s_valid & open & (state==LOAD).
- When only one request is asserted, that requester is granted.
- When both are asserted, the requester that is not last_grant is granted.
- last_grant is updated on every grant.
- cpu_ready = CPU granted; s_ready = bulk granted. Both are never 1 in the same cycle.
- s_ready is always 0 in IDLE, and cpu_ready is 0 whenever the gate is closed.

Write issue:
- On a grant, the next cycle shows pal_w_ena=1 with the granted address and data.
  - CPU: addr=cpu_addr, data=cpu_data.
  - Bulk: addr=idx (before increment), data=s_data.
- With no grant, pal_w_ena=0 next cycle and pal_w_addr/pal_w_data hold their last values.
- Back-to-back grants give back-to-back writes: one write per cycle, full throughput.

Handshake rules:
- A requester must hold valid and its payload stable until ready.
- The block never drops an accepted request.
- The CPU port is never starved during a bulk load: alternation guarantees at least every second cycle.

Test Plan:
- Idle CPU writes, GATE_VBLANK=0: cpu_addr=0x10, data=0xFF8040 -> cpu_ready same cycle; pal_w_ena=1, addr=0x10, data=0xFF8040 next cycle; ena=0 the cycle after.
- Vblank gating, GATE_VBLANK=1: cpu_valid held with vid_vblank=0 for 20 cycles -> cpu_ready=0 and no writes throughout; vid_vblank rises -> accepted that cycle; write issued 1 cycle later.
- Bulk wrap: base=0xFE, len=3, stream valid continuously -> writes at 0xFE, 0xFF, 0x00, 0x01 on 4 consecutive cycles; done pulses once after the last write; busy falls at the same time; a 5th s_valid beat is not accepted.
- Conflict: bulk active with cpu_valid and s_valid both held -> grants alternate CPU, bulk, CPU, ...; the CPU wins first after reset; pal_w_* reflects each winner with 1-cycle lag.
- Abort and restart: base=0x20, len=255, abort after 5 beats -> 5 writes at 0x20..0x24; no done; busy=0; a new bulk_start with base=0x80 begins at 0x80; a bulk_start during LOAD is ignored.
- Async reset mid-LOAD: rst_n low between clock edges -> pal_w_ena, busy and done go to 0 immediately; after release the block is IDLE and s_ready=0.
